// File: rtl/pcie_hcmd_cq_req_pkg.sv
// Shared definitions for the completion-queue request path: the FSM state
// encoding, the bit layout of a completion FIFO entry, the queue count and
// the circular tail-pointer step used by every queue.
package pcie_hcmd_cq_req_pkg;

    localparam int NUM_CQ     = 9;   // admin queue + eight I/O queues
    localparam int CQ_ENTRY_W = 79;

    // Completion FIFO entry layout
    localparam int QID_LSB    = 75;
    localparam int QID_W      = 4;
    localparam int SQID_LSB   = 71;
    localparam int SQID_W     = 4;
    localparam int SQHEAD_LSB = 63;
    localparam int SQHEAD_W   = 8;
    localparam int STATUS_LSB = 48;
    localparam int STATUS_W   = 15;
    localparam int CID_LSB    = 32;
    localparam int CID_W      = 16;
    localparam int SPEC_LSB   = 0;
    localparam int SPEC_W     = 32;

    localparam logic [QID_W-1:0] MAX_QID = QID_W'(NUM_CQ - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_MWR_REQ,
        S_UPDATE
    } cq_state_e;

    // Queue depth is 0-based, so the pointer wraps after reaching 'size'.
    function automatic logic [7:0] next_ptr(input logic [7:0] ptr, input logic [7:0] size);
        return (ptr == size) ? 8'd0 : ptr + 8'd1;
    endfunction

endpackage

// File: rtl/pcie_cq_tail_ptr.sv
// Tail pointer and phase tag for one completion queue.
//   pcie_user_clk / pcie_user_rst_n : clock, async active-low reset
//   q_rst_n   : per-queue reset (sampled), clears tail and sets phase
//   inc       : advance tail by one entry (wraps at size, toggling phase)
//   size      : 0-based queue depth
//   tail      : current tail pointer
//   phase     : phase tag written into the next completion entry
//   next_tail : tail value after the next advance
module pcie_cq_tail_ptr
    import pcie_hcmd_cq_req_pkg::*;
(
    input  logic       pcie_user_clk,
    input  logic       pcie_user_rst_n,
    input  logic       q_rst_n,
    input  logic       inc,
    input  logic [7:0] size,
    output logic [7:0] tail,
    output logic       phase,
    output logic [7:0] next_tail
);

    assign next_tail = next_ptr(tail, size);

    // NOTE: non-blocking assignments keep every register updating from the
    // pre-edge values, so readers of tail/phase in the same edge see old data.
    always_ff @(posedge pcie_user_clk or negedge pcie_user_rst_n) begin
        if (!pcie_user_rst_n) begin
            tail  <= 8'd0;
            phase <= 1'b1;
        end else if (!q_rst_n) begin
            // Queue reset wins over an advance in the same cycle.
            tail  <= 8'd0;
            phase <= 1'b1;
        end else if (inc) begin
            tail <= next_tail;
            if (tail == size) phase <= ~phase;
        end
    end

endmodule

// File: rtl/pcie_hcmd_cq_req.sv
// Completion-queue request engine. Pops completion entries from a show-ahead
// FIFO, checks the target queue is live and not full, issues one memory
// write of the 16-byte completion entry to host memory, then advances that
// queue's tail and pulses cq_post_en for the interrupt block.
//   hcmd_cq_*        : completion FIFO (empty_n / rd_data / rd_en)
//   cq_rst_n/valid   : per-queue reset and enable, bit 0 = admin
//   *_cq_size        : 0-based queue depth
//   *_cq_bs_addr     : DW-aligned queue base address
//   *_cq_head_ptr    : host-written head (sampled live)
//   *_cq_tail_ptr    : current tail
//   tx_cq_mwr_*      : memory-write request/ack, address and DW0..DW3
//   cq_post_en/qid   : one-cycle entry-posted pulse and its queue
module pcie_hcmd_cq_req
    import pcie_hcmd_cq_req_pkg::*;
#(
    parameter int C_PCIE_ADDR_WIDTH = 48
) (
    input  logic                         pcie_user_clk,
    input  logic                         pcie_user_rst_n,
    input  logic                         hcmd_cq_empty_n,
    input  logic [78:0]                  hcmd_cq_rd_data,
    output logic                         hcmd_cq_rd_en,
    input  logic [8:0]                   cq_rst_n,
    input  logic [8:0]                   cq_valid,
    input  logic [7:0]                   admin_cq_size,
    input  logic [7:0]                   io_cq1_size,
    input  logic [7:0]                   io_cq2_size,
    input  logic [7:0]                   io_cq3_size,
    input  logic [7:0]                   io_cq4_size,
    input  logic [7:0]                   io_cq5_size,
    input  logic [7:0]                   io_cq6_size,
    input  logic [7:0]                   io_cq7_size,
    input  logic [7:0]                   io_cq8_size,
    input  logic [C_PCIE_ADDR_WIDTH-1:2] admin_cq_bs_addr,
    input  logic [C_PCIE_ADDR_WIDTH-1:2] io_cq1_bs_addr,
    input  logic [C_PCIE_ADDR_WIDTH-1:2] io_cq2_bs_addr,
    input  logic [C_PCIE_ADDR_WIDTH-1:2] io_cq3_bs_addr,
    input  logic [C_PCIE_ADDR_WIDTH-1:2] io_cq4_bs_addr,
    input  logic [C_PCIE_ADDR_WIDTH-1:2] io_cq5_bs_addr,
    input  logic [C_PCIE_ADDR_WIDTH-1:2] io_cq6_bs_addr,
    input  logic [C_PCIE_ADDR_WIDTH-1:2] io_cq7_bs_addr,
    input  logic [C_PCIE_ADDR_WIDTH-1:2] io_cq8_bs_addr,
    input  logic [7:0]                   admin_cq_head_ptr,
    input  logic [7:0]                   io_cq1_head_ptr,
    input  logic [7:0]                   io_cq2_head_ptr,
    input  logic [7:0]                   io_cq3_head_ptr,
    input  logic [7:0]                   io_cq4_head_ptr,
    input  logic [7:0]                   io_cq5_head_ptr,
    input  logic [7:0]                   io_cq6_head_ptr,
    input  logic [7:0]                   io_cq7_head_ptr,
    input  logic [7:0]                   io_cq8_head_ptr,
    output logic [7:0]                   admin_cq_tail_ptr,
    output logic [7:0]                   io_cq1_tail_ptr,
    output logic [7:0]                   io_cq2_tail_ptr,
    output logic [7:0]                   io_cq3_tail_ptr,
    output logic [7:0]                   io_cq4_tail_ptr,
    output logic [7:0]                   io_cq5_tail_ptr,
    output logic [7:0]                   io_cq6_tail_ptr,
    output logic [7:0]                   io_cq7_tail_ptr,
    output logic [7:0]                   io_cq8_tail_ptr,
    output logic                         tx_cq_mwr_req,
    output logic [C_PCIE_ADDR_WIDTH-1:2] tx_cq_mwr_addr,
    output logic [31:0]                  tx_cq_mwr_data0,
    output logic [31:0]                  tx_cq_mwr_data1,
    output logic [31:0]                  tx_cq_mwr_data2,
    output logic [31:0]                  tx_cq_mwr_data3,
    input  logic                         tx_cq_mwr_req_ack,
    output logic                         cq_post_en,
    output logic [3:0]                   cq_post_qid
);

    localparam int AW = C_PCIE_ADDR_WIDTH - 2;

    logic [7:0]                   cq_size      [NUM_CQ];
    logic [C_PCIE_ADDR_WIDTH-1:2] cq_bs_addr   [NUM_CQ];
    logic [7:0]                   cq_head      [NUM_CQ];
    logic [7:0]                   cq_tail      [NUM_CQ];
    logic [7:0]                   cq_next_tail [NUM_CQ];
    logic [NUM_CQ-1:0]            cq_phase;
    logic [NUM_CQ-1:0]            tail_inc;

    assign cq_size    = '{admin_cq_size, io_cq1_size, io_cq2_size, io_cq3_size, io_cq4_size,
                          io_cq5_size, io_cq6_size, io_cq7_size, io_cq8_size};
    assign cq_bs_addr = '{admin_cq_bs_addr, io_cq1_bs_addr, io_cq2_bs_addr, io_cq3_bs_addr,
                          io_cq4_bs_addr, io_cq5_bs_addr, io_cq6_bs_addr, io_cq7_bs_addr,
                          io_cq8_bs_addr};
    assign cq_head    = '{admin_cq_head_ptr, io_cq1_head_ptr, io_cq2_head_ptr, io_cq3_head_ptr,
                          io_cq4_head_ptr, io_cq5_head_ptr, io_cq6_head_ptr, io_cq7_head_ptr,
                          io_cq8_head_ptr};

    assign admin_cq_tail_ptr = cq_tail[0];
    assign io_cq1_tail_ptr   = cq_tail[1];
    assign io_cq2_tail_ptr   = cq_tail[2];
    assign io_cq3_tail_ptr   = cq_tail[3];
    assign io_cq4_tail_ptr   = cq_tail[4];
    assign io_cq5_tail_ptr   = cq_tail[5];
    assign io_cq6_tail_ptr   = cq_tail[6];
    assign io_cq7_tail_ptr   = cq_tail[7];
    assign io_cq8_tail_ptr   = cq_tail[8];

    cq_state_e             state, next_state;
    logic [CQ_ENTRY_W-1:0] entry_q;
    logic                  qrst_seen;   // queue reset observed while a write is in flight

    logic [QID_W-1:0]             cur_qid, qsel;
    logic [C_PCIE_ADDR_WIDTH-1:2] mwr_addr_next;
    logic                         q_full, q_live;

    assign cur_qid = entry_q[QID_LSB +: QID_W];
    // Out-of-range qids never get past LOAD; clamp so the muxes stay in range.
    assign qsel    = (cur_qid > MAX_QID) ? '0 : cur_qid;

    // Head, tail and phase are selected live from the queue state, so a host
    // head update releases a stalled entry on the very next CHECK cycle.
    assign q_full        = (cq_next_tail[qsel] == cq_head[qsel]);
    assign q_live        = cq_valid[qsel] & cq_rst_n[qsel];
    assign mwr_addr_next = cq_bs_addr[qsel] + AW'({cq_tail[qsel], 2'b00});

    for (genvar i = 0; i < NUM_CQ; i++) begin : g_cq
        // A queue reset during the handshake must leave the queue at tail 0,
        // so the advance is suppressed for that entry.
        assign tail_inc[i] = (state == S_UPDATE) && (qsel == QID_W'(i)) && !qrst_seen;

        pcie_cq_tail_ptr u_tail_ptr (
            .pcie_user_clk   (pcie_user_clk),
            .pcie_user_rst_n (pcie_user_rst_n),
            .q_rst_n         (cq_rst_n[i]),
            .inc             (tail_inc[i]),
            .size            (cq_size[i]),
            .tail            (cq_tail[i]),
            .phase           (cq_phase[i]),
            .next_tail       (cq_next_tail[i])
        );
    end

    always_ff @(posedge pcie_user_clk or negedge pcie_user_rst_n) begin
        if (!pcie_user_rst_n) state <= S_IDLE;
        else                  state <= next_state;
    end

    // NOTE: next_state gets its default before the case so no path through
    // this block leaves it unassigned, which would infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:    if (hcmd_cq_empty_n) next_state = S_LOAD;
            S_LOAD:    next_state = (cur_qid > MAX_QID) ? S_IDLE : S_CHECK;
            S_CHECK: begin
                if (!q_live)     next_state = S_IDLE;
                else if (!q_full) next_state = S_MWR_REQ;
            end
            S_MWR_REQ: if (tx_cq_mwr_req_ack) next_state = S_UPDATE;
            S_UPDATE:  next_state = S_IDLE;
            default:   next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge pcie_user_clk or negedge pcie_user_rst_n) begin
        if (!pcie_user_rst_n) begin
            hcmd_cq_rd_en   <= 1'b0;
            entry_q         <= '0;
            qrst_seen       <= 1'b0;
            tx_cq_mwr_req   <= 1'b0;
            tx_cq_mwr_addr  <= '0;
            tx_cq_mwr_data0 <= '0;
            tx_cq_mwr_data1 <= '0;
            tx_cq_mwr_data2 <= '0;
            tx_cq_mwr_data3 <= '0;
            cq_post_en      <= 1'b0;
            cq_post_qid     <= '0;
        end else begin
            hcmd_cq_rd_en <= 1'b0;
            cq_post_en    <= 1'b0;
            case (state)
                S_IDLE: begin
                    // Show-ahead FIFO: the head entry is valid now and is
                    // popped by the one-cycle rd_en at the next edge.
                    if (hcmd_cq_empty_n) begin
                        hcmd_cq_rd_en <= 1'b1;
                        entry_q       <= hcmd_cq_rd_data;
                    end
                end
                S_CHECK: begin
                    if (next_state == S_MWR_REQ) begin
                        tx_cq_mwr_req   <= 1'b1;
                        tx_cq_mwr_addr  <= mwr_addr_next;
                        tx_cq_mwr_data0 <= entry_q[SPEC_LSB +: SPEC_W];
                        tx_cq_mwr_data1 <= 32'd0;
                        tx_cq_mwr_data2 <= {12'd0, entry_q[SQID_LSB +: SQID_W],
                                            8'd0, entry_q[SQHEAD_LSB +: SQHEAD_W]};
                        tx_cq_mwr_data3 <= {entry_q[STATUS_LSB +: STATUS_W], cq_phase[qsel],
                                            entry_q[CID_LSB +: CID_W]};
                    end
                end
                S_MWR_REQ: begin
                    if (!cq_rst_n[qsel])   qrst_seen     <= 1'b1;
                    if (tx_cq_mwr_req_ack) tx_cq_mwr_req <= 1'b0;
                end
                S_UPDATE: begin
                    qrst_seen   <= 1'b0;
                    cq_post_en  <= 1'b1;
                    cq_post_qid <= cur_qid;
                end
                default: ;
            endcase
        end
    end

endmodule
